// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button synchronisers, RUN/PAUSE/LAP/IDLE FSM, 1 s prescaler, lap display.
// Define STOPWATCH_DEBOUNCE_EN to add a per-button stable-level filter of DEB_CYCLES clocks.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_ss,
    input  logic       i_btn_lap,
    input  logic [3:0] i_us,
    input  logic [2:0] i_zs,
    output logic       o_cnt_start,
    output logic       o_cnt_stop,
    output logic       o_cnt_clr,
    output logic [3:0] o_disp_us,
    output logic [2:0] o_disp_zs,
    output logic [1:0] o_state,
    output logic       o_min_pulse
);
    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_sync1, r_sync2, r_lvl_d;
    logic [1:0]    w_lvl, w_ev;
    logic          w_ss_ev, w_lap_ev;
    logic [PW-1:0] r_presc;
    logic          w_running, w_tick_nxt, w_clr_nxt, w_lap_latch;
    logic [3:0]    r_lap_us;
    logic [2:0]    r_lap_zs;

    // Bit 0 carries start/stop, bit 1 carries lap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl_d <= '0;
        end else begin
            r_sync1 <= {i_btn_lap, i_btn_ss};
            r_sync2 <= r_sync1;
            r_lvl_d <= w_lvl;
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    logic [DW-1:0] r_deb_cnt [2];
    logic [1:0]    r_filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= '0;
            for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    r_filt[i]    <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end
    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync2;
`endif

    assign w_ev     = w_lvl & ~r_lvl_d;
    assign w_ss_ev  = w_ev[0];
    assign w_lap_ev = w_ev[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Start/stop always takes priority over a simultaneous lap event.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_ss_ev) w_state_nxt = S_RUN;
            S_RUN:   if (w_ss_ev) w_state_nxt = S_PAUSE; else if (w_lap_ev) w_state_nxt = S_LAP;
            S_LAP:   if (w_ss_ev) w_state_nxt = S_PAUSE; else if (w_lap_ev) w_state_nxt = S_RUN;
            S_PAUSE: if (w_ss_ev) w_state_nxt = S_RUN;   else if (w_lap_ev) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_running   = (r_state == S_RUN) || (r_state == S_LAP);
        w_tick_nxt  = w_running && (r_presc == PRESC_LAST);
        w_clr_nxt   = (r_state == S_PAUSE) && !w_ss_ev && w_lap_ev;
        w_lap_latch = (r_state == S_RUN) && !w_ss_ev && w_lap_ev;
    end

    // Prescaler holds in PAUSE so the fractional second survives a pause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc     <= '0;
            o_cnt_start <= 1'b0;
            o_cnt_stop  <= 1'b1;
            o_cnt_clr   <= 1'b0;
            o_min_pulse <= 1'b0;
            r_lap_us    <= '0;
            r_lap_zs    <= '0;
            o_disp_us   <= '0;
            o_disp_zs   <= '0;
        end else begin
            if (r_state == S_IDLE || w_state_nxt == S_IDLE)
                r_presc <= '0;
            else if (w_running)
                r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
            o_cnt_start <= w_tick_nxt;
            o_cnt_stop  <= !w_tick_nxt;
            o_cnt_clr   <= w_clr_nxt;
            o_min_pulse <= w_tick_nxt && (i_us == 4'd9) && (i_zs == 3'd5);
            if (w_lap_latch) begin
                r_lap_us <= i_us;
                r_lap_zs <= i_zs;
            end
            if (r_state == S_LAP) begin
                o_disp_us <= r_lap_us;
                o_disp_zs <= r_lap_zs;
            end else begin
                o_disp_us <= i_us;
                o_disp_zs <= i_zs;
            end
        end
    end

    assign o_state = r_state;

endmodule
